// File: rtl/ripple_carry_4bit.sv
// Registered N-bit ripple-carry adder: sum = a + b + cin with carry-out, signed
// overflow and zero flags captured one cycle after an accepted in_valid.
module ripple_carry_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             out_valid
);

  // Handshake: in_valid qualifies a/b/cin for one cycle; there is no ready, so
  // every in_valid cycle is accepted and out_valid pulses exactly one cycle later.

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_overflow;
  logic             w_zero;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_overflow;
  logic             r_zero;
  logic             r_out_valid;

  assign w_carry[0] = cin;

  // One full-adder cell per bit; the carry ripples strictly cell to cell.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic w_p;
    assign w_p            = a[i] ^ b[i];
    assign w_sum[i]       = w_p ^ w_carry[i];
    assign w_carry[i+1]   = (a[i] & b[i]) | (w_carry[i] & w_p);
  end

  assign w_overflow = w_carry[WIDTH] ^ w_carry[WIDTH-1];
  assign w_zero     = (w_sum == '0);

  // Result registers only load on in_valid, so idle-cycle X on the operands
  // never reaches the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum      <= w_sum;
        r_cout     <= w_carry[WIDTH];
        r_overflow <= w_overflow;
        r_zero     <= w_zero;
      end
    end
  end

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_overflow;
  assign zero      = r_zero;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_ripple_carry_4bit.sv
// Self-checking bench for ripple_carry_4bit: directed corner cases, exhaustive
// sweep, random traffic and async reset, against an arithmetic reference model.
module tb_ripple_carry_4bit;

  localparam int WIDTH = 4;
  localparam int W     = WIDTH + 4; // {out_valid, cout, overflow, zero, sum}

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             out_valid;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [W-2:0] held;

  ripple_carry_4bit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero),
    .out_valid (out_valid)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference model: plain integer arithmetic, signed range check for overflow.
  function automatic logic [W-1:0] model_add(input int av, input int bv, input int cv);
    int               u, sa, sb, s;
    logic [WIDTH-1:0] sv;
    logic             c, o, z;
    u  = av + bv + cv;
    sa = (av >= 2**(WIDTH-1)) ? av - 2**WIDTH : av;
    sb = (bv >= 2**(WIDTH-1)) ? bv - 2**WIDTH : bv;
    s  = sa + sb + cv;
    c  = (u >= 2**WIDTH);
    o  = (s > 2**(WIDTH-1) - 1) || (s < -(2**(WIDTH-1)));
    sv = WIDTH'(u % (2**WIDTH));
    z  = (sv == '0);
    return {1'b1, c, o, z, sv};
  endfunction

  function automatic logic [W-1:0] observed();
    return {out_valid, cout, overflow, zero, sum};
  endfunction

  task automatic reset_model();
    held = '0;
    exp_q.delete();
  endtask

  // Driver: present one cycle of stimulus at negedge, queue the expectation,
  // return just after the capturing edge.
  task automatic drive_cycle(input logic v, input int av, input int bv, input int cv);
    logic [W-1:0] e;
    @(negedge clk);
    in_valid = v;
    a        = WIDTH'(av);
    b        = WIDTH'(bv);
    cin      = cv[0];
    if (v) begin
      e    = model_add(av, bv, cv);
      held = e[W-2:0];
    end else begin
      e = {1'b0, held};
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [W-1:0] e;
    rst_n = 1'b1; in_valid = 1'b1; a = 4'hF; b = 4'h1; cin = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (observed() !== '0) begin
      failures++;
      $display("FAIL reset_immediate: got %h want %h", observed(), {W{1'b0}});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (observed() !== '0) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: got %h want %h", i, observed(), {W{1'b0}});
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    reset_model();
    drive_cycle(1'b1, 2, 3, 0);
    e = exp_q.pop_front();
    checks++;
    if (observed() !== 8'h85) begin
      failures++;
      $display("FAIL reset_first_add: got %h want %h", observed(), 8'h85);
    end
    drive_cycle(1'b0, 0, 0, 0);
    e = exp_q.pop_front();
    checks++;
    if (observed() !== 8'h05) begin
      failures++;
      $display("FAIL reset_valid_single: got %h want %h", observed(), 8'h05);
    end
  endtask

  task automatic test_exhaustive();
    logic [W-1:0] e;
    int           errs;
    errs = 0;
    for (int av = 0; av < 2**WIDTH; av++)
      for (int bv = 0; bv < 2**WIDTH; bv++)
        for (int cv = 0; cv < 2; cv++) begin
          drive_cycle(1'b1, av, bv, cv);
          e = exp_q.pop_front();
          checks++;
          if (observed() !== e) begin
            failures++;
            errs++;
            if (errs <= 10)
              $display("FAIL exhaustive a=%0d b=%0d cin=%0d: got %h want %h",
                       av, bv, cv, observed(), e);
          end
        end
  endtask

  task automatic test_carry_chain();
    logic [W-1:0] e;
    drive_cycle(1'b1, 4'hF, 4'h0, 1);
    e = exp_q.pop_front();
    checks++;
    if (observed() !== 8'hD0) begin
      failures++;
      $display("FAIL carry_wrap_zero: got %h want %h", observed(), 8'hD0);
    end
    drive_cycle(1'b1, 4'hF, 4'hF, 1);
    e = exp_q.pop_front();
    checks++;
    if (observed() !== 8'hCF) begin
      failures++;
      $display("FAIL carry_all_ones: got %h want %h", observed(), 8'hCF);
    end
    drive_cycle(1'b1, 0, 0, 0);
    e = exp_q.pop_front();
    checks++;
    if (observed() !== 8'h90) begin
      failures++;
      $display("FAIL all_zero: got %h want %h", observed(), 8'h90);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] e;
    drive_cycle(1'b1, 4'h7, 4'h1, 0);
    e = exp_q.pop_front();
    checks++;
    if (observed() !== 8'hA8) begin
      failures++;
      $display("FAIL ovf_pos: got %h want %h", observed(), 8'hA8);
    end
    drive_cycle(1'b1, 4'h8, 4'h8, 0);
    e = exp_q.pop_front();
    checks++;
    if (observed() !== 8'hF0) begin
      failures++;
      $display("FAIL ovf_neg: got %h want %h", observed(), 8'hF0);
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] e;
    drive_cycle(1'b1, 3, 4, 0);
    e = exp_q.pop_front();
    checks++;
    if (observed() !== 8'h87) begin
      failures++;
      $display("FAIL hold_capture: got %h want %h", observed(), 8'h87);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 9, 9, 1);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== 8'h07) begin
        failures++;
        $display("FAIL hold_idle cycle %0d: got %h want %h", i, observed(), 8'h07);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    for (int i = 0; i < 300; i++) begin
      drive_cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 2**WIDTH - 1),
                  $urandom_range(0, 2**WIDTH - 1), $urandom_range(0, 1));
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("FAIL random step %0d: got %h want %h", i, observed(), e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] e;
    drive_cycle(1'b1, 5, 6, 0);
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e) begin
      failures++;
      $display("FAIL midreset_pre: got %h want %h", observed(), e);
    end
    @(negedge clk);
    in_valid = 1'b1; a = 4'h9; b = 4'h2; cin = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (observed() !== '0) begin
      failures++;
      $display("FAIL midreset_immediate: got %h want %h", observed(), {W{1'b0}});
    end
    @(posedge clk); #1;
    checks++;
    if (observed() !== '0) begin
      failures++;
      $display("FAIL midreset_dropped: got %h want %h", observed(), {W{1'b0}});
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    reset_model();
    drive_cycle(1'b0, 0, 0, 0);
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e) begin
      failures++;
      $display("FAIL midreset_idle: got %h want %h", observed(), e);
    end
    drive_cycle(1'b1, 1, 1, 1);
    e = exp_q.pop_front();
    checks++;
    if (observed() !== 8'h83) begin
      failures++;
      $display("FAIL midreset_recover: got %h want %h", observed(), 8'h83);
    end
  endtask

  initial begin
    reset_model();
    test_reset();
    test_carry_chain();
    test_overflow();
    test_hold();
    test_exhaustive();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
